pool_window_gen: RTL and testbench
==================================

Name: pool_window_gen

Overview:
- Streaming front-end for the LeNet 2x2 max-pool combinational stage.
- Accepts a row-major stream of 8-bit signed feature-map pixels, buffers one row, and emits each non-overlapping 2x2 window (stride 2) as one packed 32-bit word.
- The output word is packed exactly as the max-pool stage consumes it, so the two blocks connect directly.

Parameters:
- DATA_SIZE, 8, pixel width in bits (two's-complement; passed through untouched).
- IMG_W, 28, feature-map width in pixels; even, >=2.
- IMG_H, 28, feature-map height in pixels; even, >=2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DATA_SIZE  pixel, row-major order.
- out_valid  output  1  window word valid.
- out_ready  input  1  downstream accepts the window.
- out_data  output  4*DATA_SIZE  {top-left, top-right, bottom-left, bottom-right}; top-left in bits [4*DATA_SIZE-1:3*DATA_SIZE].
- out_last  output  1  qualifies the final window of a frame; valid only with out_valid.

Behaviour:
- Reset and clocking:
  - Single clock domain. Reset is synchronous and active-low: sampled on the rising edge of clk while rst_n=0.
  - Reset values: out_valid=0, out_last=0, out_data=0, col=0, row=0, bottom-left hold reg=0.
  - Line buffer contents are not reset and are don't-care.
  - in_ready is combinational: in_ready = !(out_valid && !out_ready). It reads 1 out of reset.
- Handshakes:
  - Pixel accept: in_valid && in_ready.
  - Window transfer: out_valid && out_ready.
  - Once asserted, out_valid, out_data and out_last hold stable until transfer.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, width $clog2 of each bound.
  - Both advance only on pixel accept.
  - col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 at IMG_H-1 (end of frame). The next frame starts with no idle cycle.
- Even row (row[0]=0): the accepted pixel is written to line_buf[col]. No output.
- Odd row, even col: the accepted pixel is stored in the bottom-left hold reg. No output.
- Odd row, odd col: out_data is loaded with {line_buf[col-1], line_buf[col], hold, in_data}.
  - out_valid=1 on the next cycle (latency 1 cycle from bottom-right accept).
  - out_last=1 iff row=IMG_H-1 and col=IMG_W-1.
- Output register:
  - A transfer with no new load clears out_valid and out_last.
  - A transfer and a new load in the same cycle keep out_valid=1 with the new data, giving full throughput of 1 window per 4 pixels.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0.
  - Stalling on every pixel, not only window-completing pixels, is accepted to keep the logic simple.
  - No pixel is ever dropped or duplicated.
- Line buffer: IMG_W x DATA_SIZE register array. Write on even rows, asynchronous read on odd rows. Even-row writes cannot collide with odd-row reads.
- Reset mid-frame: the partial frame is discarded, any pending window is dropped (out_valid=0), and the next accepted pixel is treated as row 0, col 0.
- in_valid=0 cycles: counters and state hold. Idle gaps of any length are legal anywhere.
- Windows per frame: (IMG_W/2)*(IMG_H/2), which is 196 at the defaults.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 streamed with out_ready=1 -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}, i.e. out_data=32'h00010405, 32'h02030607, 32'h08090C0D, 32'h0A0B0E0F. out_last=1 only on the 4th window. Each window appears 1 cycle after its bottom-right pixel is accepted.
- Same frame with out_ready=0 for 5 cycles after the first window -> in_ready=0 throughout, out_data held at 32'h00010405, no pixel lost; remaining windows are identical to the previous test.
- Signed pass-through: pixels 8'h80, 8'h7F, 8'hFF, 8'h01 forming one window -> out_data=32'h807FFF01 unchanged.
- rst_n=0 for 1 cycle after 6 pixels of a 4x4 frame, then a full frame of 0..15 -> no stale window output, and the first window is 32'h00010405.
- Two back-to-back frames with random in_valid gaps and random out_ready -> 8 windows in order, out_last on the 4th and 8th only.
- Defaults (28x28) with a ramp of pixel=row*28+col mod 256 -> 196 windows. The first is {0,1,28,29}; out_last fires on window 196 only.

Source files
------------

// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - 2x2 stride-2 window former feeding the LeNet max-pool stage
// Buffers one even row, pairs it with the odd row and emits one packed window per 2x2 block.
module pool_window_gen #(
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DATA_SIZE-1:0] out_data,
  output logic                   out_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LSB_CLR = ~CW'(1);

  logic [DATA_SIZE-1:0] line_buf [IMG_W];
  logic [DATA_SIZE-1:0] hold;
  logic [CW-1:0]        col;
  logic [CW-1:0]        col_left;
  logic [RW-1:0]        row;
  logic                 accept;
  logic                 load;

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && row[0] && col[0];
  // Bottom-right pixels sit on odd columns, so the left neighbour is col with bit 0 cleared.
  assign col_left = col & LSB_CLR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !row[0]) begin
      line_buf[col] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (accept && row[0] && !col[0]) begin
      hold <= in_data;
    end
  end

  // A load can only happen when the output slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= (row == ROW_MAX) && (col == COL_MAX);
      out_data  <= {line_buf[col_left], line_buf[col], hold, in_data};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - randomized self-checking bench for pool_window_gen
// Drives a 4x4 and a 28x28 instance from shared inputs and scores the selected one.
module tb_pool_window_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic [7:0]  id = '0;
  logic        ordy = 1'b1;
  logic        sel = 1'b0;
  logic        ir4, ir28, ov4, ov28, ol4, ol28;
  logic [31:0] od4, od28;
  logic        ir, ov, ol;
  logic [31:0] od;

  int          n_pass = 0;
  int          n_total = 0;
  int          cur_w = 4;
  int          cur_h = 4;
  int          fpix = 0;
  int          n_win = 0;
  int          n_last = 0;
  logic [31:0] first_win;
  logic [7:0]  frame_q [$];
  logic [7:0]  px_q [$];
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_SIZE(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir4), .in_data(id),
    .out_valid(ov4), .out_ready(ordy), .out_data(od4), .out_last(ol4)
  );

  pool_window_gen #(.DATA_SIZE(8), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir28), .in_data(id),
    .out_valid(ov28), .out_ready(ordy), .out_data(od28), .out_last(ol28)
  );

  assign ir = sel ? ir28 : ir4;
  assign ov = sel ? ov28 : ov4;
  assign ol = sel ? ol28 : ol4;
  assign od = sel ? od28 : od4;

  // Reference: slice the queued frame into 2x2 blocks in raster order.
  task automatic push_frame();
    int bw;
    int nb;
    int r2;
    int c2;
    int tl;
    bw = cur_w / 2;
    nb = bw * (cur_h / 2);
    for (int i = 0; i < cur_w * cur_h; i++) px_q.push_back(frame_q[i]);
    for (int k = 0; k < nb; k++) begin
      r2 = k / bw;
      c2 = k % bw;
      tl = 2 * r2 * cur_w + 2 * c2;
      exp_q.push_back({(k == nb - 1), frame_q[tl], frame_q[tl + 1],
                       frame_q[tl + cur_w], frame_q[tl + cur_w + 1]});
    end
    frame_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    fpix = 0;
  endtask

  task automatic run_stream(input int gap_pct, input int stall_pct, input int hold_cycles, input int budget);
    int          cyc;
    int          hold_left;
    int          r;
    int          c;
    bit          br_pending;
    bit          held;
    logic [32:0] held_word;
    cyc = 0;
    hold_left = hold_cycles;
    br_pending = 1'b0;
    held = 1'b0;
    n_win = 0;
    n_last = 0;
    while ((px_q.size() > 0 || exp_q.size() > 0 || ov) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (br_pending) begin
        n_total++;
        if (ov !== 1'b1) $display("FAIL latency: out_valid=%b required 1", ov);
        else n_pass++;
      end
      if (held) begin
        n_total++;
        if ({ol, od} !== held_word) $display("FAIL hold_stable: got %h required %h", {ol, od}, held_word);
        else n_pass++;
      end
      br_pending = 1'b0;
      held = 1'b0;
      if (hold_left > 0 && ov) begin
        ordy = 1'b0;
        hold_left--;
      end else begin
        ordy = ($urandom_range(99) >= stall_pct);
      end
      if (px_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        iv = 1'b1;
        id = px_q[0];
      end else begin
        iv = 1'b0;
        id = 8'($urandom);
      end
      #1;
      if (ov && !ordy) begin
        n_total++;
        if (ir !== 1'b0) $display("FAIL stall_ready: in_ready=%b required 0", ir);
        else n_pass++;
        held = 1'b1;
        held_word = {ol, od};
      end
      if (ov && ordy) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_window: got %h required none", {ol, od});
        end else begin
          if ({ol, od} !== exp_q[0]) $display("FAIL window %0d: got %h required %h", n_win, {ol, od}, exp_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
        end
        if (n_win == 0) first_win = od;
        n_win++;
        if (ol) n_last++;
      end
      if (iv && ir) begin
        void'(px_q.pop_front());
        r = fpix / cur_w;
        c = fpix % cur_w;
        if (r % 2 == 1 && c % 2 == 1) br_pending = 1'b1;
        fpix = (fpix + 1) % (cur_w * cur_h);
      end
    end
    @(negedge clk);
    iv = 1'b0;
    ordy = 1'b1;
    n_total++;
    if (px_q.size() != 0 || exp_q.size() != 0 || ov !== 1'b0)
      $display("FAIL drain: pixels left=%0d windows left=%0d out_valid=%b required 0/0/0", px_q.size(), exp_q.size(), ov);
    else n_pass++;
    px_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    #1;
    n_total++;
    if ({ov4, ol4, od4, ir4} !== {1'b0, 1'b0, 32'h0, 1'b1})
      $display("FAIL reset4: v/l/d/rdy=%b/%b/%h/%b required 0/0/00000000/1", ov4, ol4, od4, ir4);
    else n_pass++;
    n_total++;
    if ({ov28, ol28, od28, ir28} !== {1'b0, 1'b0, 32'h0, 1'b1})
      $display("FAIL reset28: v/l/d/rdy=%b/%b/%h/%b required 0/0/00000000/1", ov28, ol28, od28, ir28);
    else n_pass++;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    cur_w = 4;
    cur_h = 4;
    do_reset();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    push_frame();
    run_stream(0, 0, 0, 200);
    n_total++;
    if (first_win !== 32'h00010405) $display("FAIL basic_first: got %h required 00010405", first_win);
    else n_pass++;
    n_total++;
    if (n_win != 4 || n_last != 1) $display("FAIL basic_count: windows=%0d lasts=%0d required 4/1", n_win, n_last);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    push_frame();
    run_stream(0, 0, 5, 200);
    n_total++;
    if (first_win !== 32'h00010405) $display("FAIL bp_first: got %h required 00010405", first_win);
    else n_pass++;
    n_total++;
    if (n_win != 4) $display("FAIL bp_count: windows=%0d required 4", n_win);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [7:0] corner [4];
    corner[0] = 8'h80;
    corner[1] = 8'h7F;
    corner[2] = 8'hFF;
    corner[3] = 8'h01;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'($urandom));
    frame_q[0] = corner[0];
    frame_q[1] = corner[1];
    frame_q[4] = corner[2];
    frame_q[5] = corner[3];
    push_frame();
    run_stream(20, 20, 0, 400);
    n_total++;
    if (first_win !== 32'h807FFF01) $display("FAIL signed: got %h required 807FFF01", first_win);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ordy = 1'b0;
      iv = 1'b1;
      id = 8'(i + 100);
    end
    @(negedge clk);
    iv = 1'b0;
    n_total++;
    if (ov4 !== 1'b1) $display("FAIL midrst_pending: out_valid=%b required 1", ov4);
    else n_pass++;
    do_reset();
    #1;
    n_total++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) $display("FAIL midrst_cleared: out_valid=%b in_ready=%b required 0/1", ov4, ir4);
    else n_pass++;
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    push_frame();
    run_stream(0, 0, 0, 200);
    n_total++;
    if (first_win !== 32'h00010405) $display("FAIL midrst_first: got %h required 00010405", first_win);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) frame_q.push_back(8'($urandom));
      push_frame();
    end
    run_stream(30, 30, 0, 1000);
    n_total++;
    if (n_win != 8 || n_last != 2) $display("FAIL b2b_count: windows=%0d lasts=%0d required 8/2", n_win, n_last);
    else n_pass++;
  endtask

  task automatic test_ramp28();
    sel = 1'b1;
    cur_w = 28;
    cur_h = 28;
    do_reset();
    for (int i = 0; i < 784; i++) frame_q.push_back(8'(i));
    push_frame();
    run_stream(10, 10, 0, 3000);
    n_total++;
    if (first_win !== 32'h00011C1D) $display("FAIL ramp_first: got %h required 00011c1d", first_win);
    else n_pass++;
    n_total++;
    if (n_win != 196 || n_last != 1) $display("FAIL ramp_count: windows=%0d lasts=%0d required 196/1", n_win, n_last);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_signed();
    test_mid_reset();
    test_back_to_back();
    test_ramp28();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
